piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serialiser with a valid/ready word input and a bit-serial output.
- A one-word holding buffer lets the next word be accepted while the current one shifts, giving gapless back-to-back frames.
- A shift-enable input paces output to an external bit tick (baud divider, SPI clock-enable). Bit order is selectable.
- Sits between a word-oriented producer (FIFO, register bank) and a serial line driver.

Parameters:
- WIDTH, 8, bits per word; legal range 2..64.
- LSB_FIRST, 0, 0 = transmit IN_DATA[WIDTH-1] first; 1 = transmit IN_DATA[0] first.
- IDLE_LEVEL, 0, value driven on SER_OUT while SER_VALID=0.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_DATA  input  WIDTH  parallel word.
- IN_VALID  input  1  producer has a word.
- IN_READY  output  1  holding buffer empty; word accepted on an edge where IN_VALID&&IN_READY.
- SHIFT_EN  input  1  advance one bit on this edge (tie 1 for one bit per cycle).
- SER_OUT  output  1  current serial bit.
- SER_VALID  output  1  SER_OUT carries frame data.
- SER_LAST  output  1  current bit is the final bit of the word.
- BUSY  output  1  hold buffer full or frame in progress.

Behaviour:
- Reset (synchronous, RST=1 at an edge):
  - hold_full=0, shreg=0, bit_cnt=0, state=IDLE.
  - Outputs after that edge: IN_READY=1, SER_VALID=0, SER_LAST=0, BUSY=0, SER_OUT=IDLE_LEVEL.
  - Reset mid-frame discards both the in-flight word and the held word. RST has priority over every other event.
- Registers:
  - hold[WIDTH-1:0] and hold_full.
  - shreg[WIDTH-1:0].
  - bit_cnt of $clog2(WIDTH) bits.
  - state in {IDLE, SHIFT}.
- IN_READY = ~hold_full. It is driven only from registers, with no combinational path from SHIFT_EN or IN_VALID.
- Accept: on an edge with IN_VALID && IN_READY, hold <= IN_DATA and hold_full <= 1.
- IDLE -> SHIFT: on an edge with state=IDLE and hold_full=1:
  - shreg <= hold, hold_full <= 0, bit_cnt <= 0.
  - This transfer does not depend on SHIFT_EN.
  - A word accepted at edge k produces SER_VALID=1 and its first bit after edge k+1.
- SHIFT, advancing: on an edge with SHIFT_EN=1 and bit_cnt < WIDTH-1, shreg shifts one position toward the output end and bit_cnt increments.
- SHIFT, holding: with SHIFT_EN=0, all of SER_OUT, SER_LAST and bit_cnt hold.
- SHIFT, last bit (SHIFT_EN=1 and bit_cnt = WIDTH-1):
  - If hold_full=1: reload shreg <= hold, clear hold_full, bit_cnt <= 0, stay in SHIFT. This is the gapless case: no idle bit between words.
  - Else: go to IDLE and SER_VALID drops.
- Same-edge accept and drain: the hold buffer may be drained and refilled on the same edge only if IN_READY was already 1. Because IN_READY is registered, a full buffer being drained still shows IN_READY=0 that cycle. The word is then accepted one cycle later. There is no throughput loss because WIDTH >= 2.
- Output decode:
  - SER_OUT = shreg[WIDTH-1] when LSB_FIRST=0, else shreg[0]. It is forced to IDLE_LEVEL when state=IDLE.
  - SER_VALID = (state==SHIFT).
  - SER_LAST = SER_VALID && (bit_cnt == WIDTH-1).
  - BUSY = SER_VALID || hold_full.
- Shift fill: vacated shreg bits fill with 0. No X is ever observable on SER_OUT.
- SHIFT_EN in IDLE is ignored.

Decomposition:
- Package piso_pkg holds:
  - typedef enum {PISO_IDLE, PISO_SHIFT} piso_state_t;
  - function piso_cnt_w(width) returning $clog2(width).
- Optional sub-module piso_hold_buf: the one-word valid/ready skid register (hold, hold_full, IN_READY). It is reused elsewhere in front of serial blocks.
- The shifter, counter and FSM stay in piso_stream.

Test Plan:
- WIDTH=8, LSB_FIRST=0, IDLE_LEVEL=0, SHIFT_EN=1, send 0xB2 -> SER_OUT 1,0,1,1,0,0,1,0 over 8 cycles starting one cycle after accept; SER_LAST only on the 8th bit; then SER_OUT=0 and SER_VALID=0.
- Same stimulus with LSB_FIRST=1 -> SER_OUT 0,1,0,0,1,1,0,1.
- Back-to-back 0xB2 then 0x0F, IN_VALID held high -> 16 consecutive valid bits with no gap (10110010 00001111); IN_READY low exactly while hold is full; a third word stalls until the first reload.
- SHIFT_EN toggling 1,0,1,0..., word 0xB2 -> each bit held 2 cycles, frame lasts 16 cycles, bit_cnt frozen on SHIFT_EN=0 cycles.
- RST asserted at bit 4 of 0xB2 with 0x0F held -> next cycle SER_VALID=0, BUSY=0, IN_READY=1, SER_OUT=IDLE_LEVEL; 0x0F never transmitted.
- IDLE_LEVEL=1, WIDTH=2, word 0b10 -> SER_OUT idles 1, then 1,0, then returns to 1; SER_LAST on the 2nd bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serialiser family.
package piso_pkg;

    typedef enum logic [0:0] {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_t;

    // Bit-counter width; never below 1 so WIDTH=2 still gets a real register.
    function automatic int piso_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-word valid/ready holding register; ready is a pure register output.
// Latency: word visible on hold_o the cycle after acceptance; no same-edge refill while full.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             drain_i,
    output logic [WIDTH-1:0] hold_o,
    output logic             hold_full_o
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;

    assign accept = in_valid_i && !hold_full_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (drain_i) begin
            hold_full_d = 1'b0;
        end
        // Accept and drain are exclusive: accept needs empty, drain needs full.
        if (accept) begin
            hold_d      = in_data_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign in_ready_o  = !hold_full_q;
    assign hold_o      = hold_q;
    assign hold_full_o = hold_full_q;

endmodule

// File: rtl/piso_stream.sv
// Word-to-bit serialiser with one-word hold buffer for gapless back-to-back frames.
// First bit appears one cycle after the word's transfer edge; SHIFT_EN paces bits.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             SHIFT_EN,
    output logic             SER_OUT,
    output logic             SER_VALID,
    output logic             SER_LAST,
    output logic             BUSY
);

    localparam int             CW       = piso_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             drain;

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_i       (CLK),
        .rst_i       (RST),
        .in_data_i   (IN_DATA),
        .in_valid_i  (IN_VALID),
        .in_ready_o  (IN_READY),
        .drain_i     (drain),
        .hold_o      (hold),
        .hold_full_o (hold_full)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        drain     = 1'b0;
        case (state_q)
            PISO_IDLE: begin
                if (hold_full) begin
                    shreg_d   = hold;
                    bit_cnt_d = '0;
                    state_d   = PISO_SHIFT;
                    drain     = 1'b1;
                end
            end
            PISO_SHIFT: begin
                if (SHIFT_EN) begin
                    if (bit_cnt_q == LAST_CNT) begin
                        // Reload straight from hold so no idle bit separates words.
                        if (hold_full) begin
                            shreg_d   = hold;
                            bit_cnt_d = '0;
                            drain     = 1'b1;
                        end else begin
                            shreg_d   = '0;
                            bit_cnt_d = '0;
                            state_d   = PISO_IDLE;
                        end
                    end else begin
                        shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = PISO_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= PISO_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign SER_VALID = (state_q == PISO_SHIFT);
    assign SER_OUT   = SER_VALID ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]) : IDLE_LEVEL;
    assign SER_LAST  = SER_VALID && (bit_cnt_q == LAST_CNT);
    assign BUSY      = SER_VALID || hold_full;

endmodule

// File: tb/tb_piso_stream.sv
// Three serialiser configurations driven by one producer, checked cycle by cycle
// against a frame-level model (current word plus bits remaining, one held word).
module tb_piso_stream;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       SHIFT_EN;
    logic [2:0] rdy, so, sv, sl, bsy;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // 0: W8 MSB-first idle 0; 1: W8 LSB-first idle 0; 2: W2 MSB-first idle 1
    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut0 (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(rdy[0]),
        .SHIFT_EN(SHIFT_EN), .SER_OUT(so[0]), .SER_VALID(sv[0]), .SER_LAST(sl[0]), .BUSY(bsy[0]));
    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut1 (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(rdy[1]),
        .SHIFT_EN(SHIFT_EN), .SER_OUT(so[1]), .SER_VALID(sv[1]), .SER_LAST(sl[1]), .BUSY(bsy[1]));
    piso_stream #(.WIDTH(2), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut2 (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA[1:0]), .IN_VALID(IN_VALID), .IN_READY(rdy[2]),
        .SHIFT_EN(SHIFT_EN), .SER_OUT(so[2]), .SER_VALID(sv[2]), .SER_LAST(sl[2]), .BUSY(bsy[2]));

    int         mw [3] = '{8, 8, 2};
    bit         ml [3] = '{1'b0, 1'b1, 1'b0};
    bit         mi [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] m_hold [3];
    logic [7:0] m_word [3];
    bit         m_full [3];
    int         m_left [3];

    logic [63:0] cap [3];
    int          nb [3];
    int          vcnt [3];
    int          falls [3];
    logic [2:0]  obs_so, obs_sv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_bit(input int k);
        int i;
        i = mw[k] - m_left[k];
        return ml[k] ? m_word[k][i] : m_word[k][mw[k]-1-i];
    endfunction

    task automatic model_edge(input int k);
        bit acc, drain;
        if (RST) begin
            m_full[k] = 1'b0;
            m_left[k] = 0;
            return;
        end
        acc   = IN_VALID && !m_full[k];
        drain = 1'b0;
        if (m_left[k] == 0) begin
            if (m_full[k]) begin
                m_word[k] = m_hold[k];
                m_left[k] = mw[k];
                drain     = 1'b1;
            end
        end else if (SHIFT_EN) begin
            if (m_left[k] == 1 && m_full[k]) begin
                m_word[k] = m_hold[k];
                m_left[k] = mw[k];
                drain     = 1'b1;
            end else begin
                m_left[k]--;
            end
        end
        if (drain) m_full[k] = 1'b0;
        if (acc) begin
            m_hold[k] = IN_DATA & (8'hFF >> (8 - mw[k]));
            m_full[k] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!RST && SHIFT_EN && m_left[k] > 0) begin
                cap[k] = {cap[k][62:0], obs_so[k]};
                nb[k]++;
            end
            model_edge(k);
            chk($sformatf("rdy%0d", k),  64'(rdy[k]), 64'(!m_full[k]));
            chk($sformatf("sv%0d", k),   64'(sv[k]),  64'(m_left[k] > 0));
            chk($sformatf("last%0d", k), 64'(sl[k]),  64'(m_left[k] == 1));
            chk($sformatf("busy%0d", k), 64'(bsy[k]), 64'(m_left[k] > 0 || m_full[k]));
            chk($sformatf("so%0d", k),   64'(so[k]),  64'((m_left[k] > 0) ? exp_bit(k) : mi[k]));
            if (sv[k]) vcnt[k]++;
            if (obs_sv[k] && !sv[k]) falls[k]++;
        end
        obs_so = so;
        obs_sv = sv;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 3; k++) begin
            cap[k] = '0; nb[k] = 0; vcnt[k] = 0; falls[k] = 0;
        end
    endtask

    // Present words in order, holding IN_VALID until instance 0 takes each one.
    task automatic send0(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input int n);
        logic [7:0] w [3];
        int idx, budget;
        bit acc0;
        w = '{w0, w1, w2};
        idx = 0; budget = 0;
        IN_VALID = 1'b1;
        IN_DATA  = w[0];
        while (idx < n && budget < 100) begin
            acc0 = !m_full[0];
            step();
            budget++;
            if (acc0) begin
                idx++;
                if (idx < n) IN_DATA = w[idx];
            end
        end
        IN_VALID = 1'b0;
        chk("send_timeout", 64'(idx), 64'(n));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int budget;
        RST = 1'b1; IN_DATA = '0; IN_VALID = 1'b0; SHIFT_EN = 1'b1;
        obs_so = '0; obs_sv = '0;
        for (int k = 0; k < 3; k++) begin
            m_hold[k] = '0; m_word[k] = '0; m_full[k] = 1'b0; m_left[k] = 0;
        end
        clear_stats();
        step();
        step();
        RST = 1'b0;
        idle_steps(2);

        // Single word 0xB2, one bit per cycle
        clear_stats();
        send0(8'hB2, 8'h00, 8'h00, 1);
        idle_steps(12);
        chk("b2_msb_bits", cap[0] & 64'hFF, 64'hB2);
        chk("b2_msb_cnt", 64'(nb[0]), 64'd8);
        chk("b2_lsb_bits", cap[1] & 64'hFF, 64'h4D);
        chk("w2_bits", cap[2] & 64'h3, 64'h2);
        chk("b2_valid_cycles", 64'(vcnt[0]), 64'd8);

        // Back-to-back words with a third word stalling on the hold buffer
        clear_stats();
        send0(8'hB2, 8'h0F, 8'h55, 3);
        idle_steps(30);
        chk("b2b_bits", cap[0] & 64'hFFFFFF, 64'hB20F55);
        chk("b2b_valid_cycles", 64'(vcnt[0]), 64'd24);
        chk("b2b_gapless", 64'(falls[0]), 64'd1);

        // Alternating SHIFT_EN: every bit held two cycles
        clear_stats();
        SHIFT_EN = 1'b1;
        send0(8'hB2, 8'h00, 8'h00, 1);
        step();
        for (int i = 0; i < 24; i++) begin
            SHIFT_EN = (i % 2) == 1;
            step();
        end
        SHIFT_EN = 1'b1;
        idle_steps(4);
        chk("toggle_bits", cap[0] & 64'hFF, 64'hB2);
        chk("toggle_valid_cycles", 64'(vcnt[0]), 64'd16);

        // Reset in mid-frame with a second word waiting in hold
        clear_stats();
        send0(8'hB2, 8'h0F, 8'h00, 2);
        budget = 0;
        while (nb[0] < 4 && budget < 50) begin
            step();
            budget++;
        end
        chk("rst_wait_timeout", 64'(nb[0]), 64'd4);
        RST = 1'b1;
        step();
        RST = 1'b0;
        idle_steps(20);
        chk("rst_no_more_bits", 64'(nb[0]), 64'd4);
        chk("rst_prefix", cap[0] & 64'hF, 64'hB);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            IN_VALID = $urandom_range(0, 3) != 0;
            IN_DATA  = 8'($urandom);
            SHIFT_EN = $urandom_range(0, 3) != 0;
            RST      = $urandom_range(0, 299) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
